// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/cond_negate.sv
// Two's-complement conditional negate; purely combinational.
// Zero latency, no flow control.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Latency WIDTH+1 edges from accept to HI/LO update; start and MTHI/MTLO are ignored while busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz_pulse;

  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_sa     = w_signed & a[WIDTH-1];
  assign w_sb     = w_signed & b[WIDTH-1];

  cond_negate #(.WIDTH(WIDTH)) u_abs_a (.i_neg(w_sa), .i_val(a), .o_val(w_abs_a));
  cond_negate #(.WIDTH(WIDTH)) u_abs_b (.i_neg(w_sb), .i_val(b), .o_val(w_abs_b));

  // Multiply step adds |b| into the upper half; divide step is a restoring trial subtract.
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_dvs};
  assign w_shift = {r_acc, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

  cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.i_neg(r_neg_q), .i_val({r_acc, r_q}), .o_val(w_prod_fix));
  cond_negate #(.WIDTH(WIDTH))   u_fix_quo  (.i_neg(r_neg_q), .i_val(r_q),          .o_val(w_quo_fix));
  cond_negate #(.WIDTH(WIDTH))   u_fix_rem  (.i_neg(r_neg_r), .i_val(r_acc),        .o_val(w_rem_fix));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz       <= 1'b0;
      r_acc       <= '0;
      r_q         <= '0;
      r_dvs       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_is_div <= (op == OP_DIV) || (op == OP_DIVU);
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_dbz    <= (b == '0);
            r_acc    <= '0;
            r_q      <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_cnt    <= CNT_W'(WIDTH);
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_is_div) begin
            r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
          end else if (r_q[0]) begin
            r_acc <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end else begin
            r_acc <= r_acc >> 1;
            r_q   <= {r_acc[0], r_q[WIDTH-1:1]};
          end
        end
        ST_FIX: begin
          r_done <= 1'b1;
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod_fix;
          end else begin
            // Zero divisor leaves the dividend as remainder; quotient is forced to all ones.
            r_hi        <= w_rem_fix;
            r_lo        <= r_dbz ? '1 : w_quo_fix;
            r_dbz_pulse <= r_dbz;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz_pulse;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op, let the next edge accept it, then scramble the operand inputs.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                       input logic edbz);
    int n;
    start_op(o, x, y);
    check({tag, "_busy"}, busy, 1);
    wait_done(n);
    check({tag, "_lat"}, n, 33);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_dbz"}, div_by_zero, edbz);
    tick();
    check({tag, "_done_1cyc"}, {done, div_by_zero}, 0);
  endtask

  initial begin
    int n;
    int done_seen;
    int busy_seen;
    rstn  = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    #1 rstn = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    #9 rstn = 1'b1;

    do_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    do_op("mult_neg",  MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    do_op("div_neg",   DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    do_op("div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    do_op("divu_z",    DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1);
    do_op("div_z",     DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    do_op("divu_big",  DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0);
    do_op("mult_min",  MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);

    hi_we = 1'b1;
    wdata = 32'hAAAA5555;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = 32'h0F0F0F0F;
    tick();
    lo_we = 1'b0;
    check("mthi", hi, 32'hAAAA5555);
    check("mtlo", lo, 32'h0F0F0F0F);

    hi_we = 1'b1;
    wdata = 32'h0000DEAD;
    start_op(MULTU, 32'd2, 32'd3);
    hi_we = 1'b0;
    check("we_start_hi", hi, 32'h0000DEAD);
    wait_done(n);
    check("we_start_lat", n, 33);
    check("we_start_rhi", hi, 0);
    check("we_start_rlo", lo, 6);

    start_op(MULTU, 32'd5, 32'd6);
    repeat (9) tick();
    start = 1'b1;
    op    = DIV;
    a     = 32'd1;
    b     = 32'd1;
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h00001234;
    tick();
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("busy_we_hi", hi, 0);
    check("busy_we_lo", lo, 6);
    wait_done(n);
    check("busy_start_lat", n, 23);
    check("busy_start_hi", hi, 0);
    check("busy_start_lo", lo, 30);
    start_op(MULTU, 32'd7, 32'd9);
    check("b2b_busy", busy, 1);
    wait_done(n);
    check("b2b_lat", n, 33);
    check("b2b_lo", lo, 63);
    tick();

    start_op(DIV, 32'd100, 32'd7);
    repeat (9) tick();
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    #3 rstn = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    check("post_rst_done", done_seen, 0);
    check("post_rst_busy", busy_seen, 0);
    do_op("recover", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
